mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle memory responder on the far end of the control path's memory request interface: it accepts the `mem_read` / `mem_write` strobes the multi-cycle control unit issues, performs the word access after a programmable latency, and signals completion with a one-cycle `mem_ready` pulse. It sits between the datapath's address/write-data mux (`i_or_d` selected) and the instruction/data register inputs. It replaces the zero-latency memory model, so stall handling in the control unit can be exercised.

## Interface
- `ADDR_WIDTH`, 8, number of word-index bits; storage depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2, clock edges from the request-accept edge to the `mem_ready` rising edge; legal range 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces idle state and clears all outputs.
- `mem_read`  in  1  read request strobe.
- `mem_write`  in  1  write request strobe.
- `addr`  in  32  byte address; word index is `addr[ADDR_WIDTH+1:2]`.
- `din`  in  32  write data.
- `dout`  out  32  read data; holds the last completed read.
- `mem_ready`  out  1  one-cycle completion pulse for a read or a write.
- `busy`  out  1  high whenever a request is in flight (state not IDLE).
- `err`  out  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: a request is valid when exactly one of `mem_read` / `mem_write` is high and `addr[1:0] == 0`.
  - On a valid request, latch op, word index and `din`, load counter with LATENCY-1, and go to WAIT.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access and go to RESP with `mem_ready` <= 1:
    - read: `dout` <= mem[index];
    - write: mem[index] <= latched din.
- RESP: `mem_ready` <= 0; go to IDLE. Requests present in RESP are ignored.
- Inputs are sampled only on the accept edge. Changes to `addr`, `din` or the strobes during WAIT or RESP have no effect.
- Rejection, IDLE only, no access, no state change, `err` <= 1 for the next cycle:
  - both strobes high;
  - either strobe high with `addr[1:0] != 0`.
  - A rejected request held high produces `err` every cycle.
- `err` <= 0 on every edge without a rejection.
- Upper address bits `addr[31:ADDR_WIDTH+2]` are ignored. Indices wrap modulo 2^ADDR_WIDTH; there is no out-of-range error.
- A write does not change `dout`. `dout` changes only when a read completes.
- Storage contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, `dout` 0, `mem_ready` 0, `busy` 0, `err` 0. They take effect immediately when `reset` asserts, independent of `clk`.
- Reset mid-operation: the in-flight request is dropped. A pending write is never committed, and a pending read leaves `dout` at 0.
- Accept on edge N: `busy` is high from edge N.
- `mem_ready` and the access (read data in `dout`, write committed) occur on edge N+LATENCY. `mem_ready` is high for exactly one cycle.
- `busy` falls at edge N+LATENCY+1. The next request can be accepted no earlier than edge N+LATENCY+2.
- Minimum occupancy is LATENCY+2 cycles per request.
- `busy`, `mem_ready` and `err` are all registered outputs. There are no combinational paths from inputs to outputs.

## Test plan
- LATENCY=2: write 0xDEADBEEF to addr 0x10 (accept edge N), then read 0x10.
  - Write: `mem_ready` pulses at N+2 and `busy` is high over edges N..N+2.
  - Read: `dout` = 0xDEADBEEF with `mem_ready` two edges after its accept; `dout` is unchanged by the write.
- Misaligned and conflicting requests:
  - `mem_read` with addr 0x12 in IDLE -> `err` = 1 next cycle, `busy` stays 0, `dout` unchanged.
  - Both strobes high -> `err`, no access.
- Wrap-around, ADDR_WIDTH=8: write 0x1234 to addr 0x400, then read addr 0x0 -> `dout` = 0x1234.
- Input change during WAIT: accept a read of 0x20 (holding 0xA5), then change `addr` to 0x24 and drop `mem_read` mid-WAIT -> `dout` = 0xA5, a single `mem_ready` pulse.
- Async reset mid-write:
  - Preload addr 0x8 with 0x1111, then accept a write of 0x2222 to 0x8.
  - Assert `reset` between edges during WAIT -> `busy` / `mem_ready` drop to 0 immediately.
  - A subsequent read of 0x8 returns 0x1111.
- LATENCY=1, back-to-back reads held high continuously -> accepts every 3 cycles (LATENCY+2), with one `mem_ready` per access and no pulse during RESP re-sampling.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-cycle word memory responder with programmable latency
// Accepts one read/write strobe in IDLE, completes it LATENCY edges later with a one-cycle mem_ready_o pulse.
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] din_i,
    output logic [31:0] dout_o,
    output logic        mem_ready_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_rd_q, op_rd_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             dout_q, dout_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    mem_we;
    logic [31:0]             mem_q [DEPTH];

    logic req_any;
    logic req_ok;
    logic unused_addr_hi;

    assign req_any = mem_read_i | mem_write_i;
    assign req_ok  = (mem_read_i ^ mem_write_i) && (addr_i[1:0] == 2'b00);
    // Upper address bits alias onto the same words; indices wrap silently.
    assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH+2];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_rd_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_rd_q <= op_rd_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; mem_we is gated by state_q, so an aborted write never lands.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_ok) state_d = S_WAIT;
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_rd_d = op_rd_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    op_rd_d = mem_read_i;
                    idx_d   = addr_i[ADDR_WIDTH+1:2];
                    wdata_d = din_i;
                    cnt_d   = CNT_INIT;
                end else if (req_any) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (op_rd_q) begin
                        dout_d = mem_q[idx_q];
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        mem_ready_o = ready_q;
        err_o       = err_q;
        dout_o      = dout_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 2 and LATENCY 1
module tb_mem_responder;

    localparam int LAT0 = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, din = '0;
    logic [31:0] dout;
    logic        mem_ready, busy, err;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, din1 = '0;
    logic [31:0] dout1;
    logic        rdy1, busy1, err1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [256];
    logic [31:0] exp_dout = '0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT0)) u_dut (
        .clk_i(clk), .reset_i(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .addr_i(addr), .din_i(din), .dout_o(dout), .mem_ready_o(mem_ready),
        .busy_o(busy), .err_o(err)
    );

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .mem_read_i(rd1), .mem_write_i(wr1),
        .addr_i(addr1), .din_i(din1), .dout_o(dout1), .mem_ready_o(rdy1),
        .busy_o(busy1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every completion pops the dout value the model predicts.
    always @(negedge clk) begin
        if (mem_ready) begin
            chk("sb_pending", sb.size(), 1);
            if (sb.size() > 0) chk("sb_dout", dout, sb.pop_front());
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        int lat;
        lat = 0;
        mem_read = rd; mem_write = wr; addr = a; din = d;
        @(posedge clk); #1;
        if (wr) mdl[a[9:2]] = d;
        else    exp_dout = mdl[a[9:2]];
        sb.push_back(exp_dout);
        chk("busy_accept", busy, 1);
        addr = a + 32'd4; din = ~d;
        if (hold == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == hold) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (mem_ready) begin lat = k; break; end
            chk("busy_wait", busy, 1);
        end
        chk("latency", lat, LAT0);
        chk("busy_at_ready", busy, 1);
        @(posedge clk); #1;
        chk("busy_fall", busy, 0);
        chk("ready_one_cycle", mem_ready, 0);
    endtask

    task automatic reject(input logic rd, input logic wr, input logic [31:0] a, input int ncyc);
        mem_read = rd; mem_write = wr; addr = a; din = 32'h5555_5555;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_dout", dout, exp_dout);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        chk("err_clear", err, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk); #1 reset = 1'b0;

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0);

        reject(1'b1, 1'b0, 32'h12, 2);
        reject(1'b1, 1'b1, 32'h10, 1);
        reject(1'b0, 1'b1, 32'h13, 1);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0);

        access(1'b0, 1'b1, 32'h400, 32'h1234, 0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 0);

        access(1'b0, 1'b1, 32'h20, 32'hA5, 0);
        access(1'b0, 1'b1, 32'h24, 32'h5A, 0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1);

        access(1'b0, 1'b1, 32'h8, 32'h1111, 0);
        mem_write = 1'b1; addr = 32'h8; din = 32'h2222;
        @(posedge clk); #1;
        mem_write = 1'b0;
        chk("rst_mid_busy_pre", busy, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", mem_ready, 0);
        chk("rst_mid_dout", dout, 0);
        exp_dout = '0;
        sb.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", mem_ready, 0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 0);

        wr1 = 1'b1; addr1 = 32'h0; din1 = 32'h77;
        @(posedge clk); #1 wr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("l1_idle", busy1, 0);
        rd1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk("l1_ready", rdy1, (k % 3) == 1);
            chk("l1_busy", busy1, (k % 3) != 2);
            chk("l1_err", err1, 0);
            if ((k % 3) == 1) chk("l1_dout", dout1, 32'h77);
        end
        rd1 = 1'b0;

        repeat (3) @(posedge clk);
        #1 chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
